pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipe_pkg.sv | 15 +
 rtl/hazard_detect.sv | 28 ++
 rtl/pipeline_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard/flush controller.
// Build option: PIPE_CTRL_PERF_EN (see pipeline_ctrl.sv).
package pipe_pkg;

  // Controller operating mode.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } pipe_state_e;

  localparam int REG_W  = 5;
  localparam int PERF_W = 32;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the D-register consumer and the E-register
// producer. Purely combinational; r0 never creates a dependency.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic [REG_W-1:0] d_ra,
  input  logic [REG_W-1:0] d_rb,
  input  logic             d_need_ra,
  input  logic             d_need_rb,
  input  logic [REG_W-1:0] e_rn,
  input  logic             e_wreg,
  input  logic             e_m2reg,
  output logic             load_use
);

  logic e_is_load_dst;
  logic hit_ra;
  logic hit_rb;

  // A load in E whose result a D operand still needs.
  always_comb begin
    e_is_load_dst = e_wreg && e_m2reg && (e_rn != '0);
    hit_ra        = d_need_ra && (d_ra == e_rn);
    hit_rb        = d_need_rb && (d_rb == e_rn);
    load_use      = e_is_load_dst && (hit_ra || hit_rb);
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/bubble controller: load-use interlock, memory wait hold and
// redirect flush sequencing.
// Build option: define PIPE_CTRL_PERF_EN to build the stall/flush counters;
// without it both counter outputs are tied to zero.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// RUN      | normal flow; load-use interlock active
// MEM_WAIT | M-register access outstanding; F..M held, W fed bubbles
// FLUSH    | fetch still returning wrong-path words; T fed bubbles
//
// A memory wait that starts during FLUSH freezes the flush count (fetch is
// held too) and FLUSH resumes with the remaining count once the access ends.
module pipeline_ctrl
  import pipe_pkg::*;
#(
  parameter int FLUSH_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_W-1:0]  d_ra,
  input  logic [REG_W-1:0]  d_rb,
  input  logic              d_need_ra,
  input  logic              d_need_rb,
  input  logic [REG_W-1:0]  e_rn,
  input  logic              e_wreg,
  input  logic              e_m2reg,
  input  logic              e_redirect,
  input  logic              m_mem_req,
  input  logic              m_mem_ready,
  output logic              t_stall,
  output logic              d_stall,
  output logic              e_stall,
  output logic              m_stall,
  output logic              f_stall,
  output logic              t_bubble,
  output logic              d_bubble,
  output logic              e_bubble,
  output logic              w_bubble,
  output logic [PERF_W-1:0] perf_stall_cnt,
  output logic [PERF_W-1:0] perf_flush_cnt
);

  localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_LAT - 1);

  pipe_state_e state, state_n;
  logic [1:0]  flush_cnt, flush_cnt_n;
  logic        redirect_pend, redirect_pend_n;

  logic load_use;
  logic mem_hold;
  logic redirect_go;

  logic f_stall_raw, t_stall_raw, d_stall_raw, e_stall_raw, m_stall_raw;
  logic t_bubble_raw, d_bubble_raw, e_bubble_raw, w_bubble_raw;

  hazard_detect u_hazard_detect (
    .d_ra      (d_ra),
    .d_rb      (d_rb),
    .d_need_ra (d_need_ra),
    .d_need_rb (d_need_rb),
    .e_rn      (e_rn),
    .e_wreg    (e_wreg),
    .e_m2reg   (e_m2reg),
    .load_use  (load_use)
  );

  // Controller state, flush countdown and deferred-redirect flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= RUN;
      flush_cnt     <= 2'd0;
      redirect_pend <= 1'b0;
    end else begin
      state         <= state_n;
      flush_cnt     <= flush_cnt_n;
      redirect_pend <= redirect_pend_n;
    end
  end

  // Next state and raw stall/bubble requests; memory wait > redirect > load-use.
  always_comb begin
    state_n         = state;
    flush_cnt_n     = flush_cnt;
    redirect_pend_n = redirect_pend;
    mem_hold        = 1'b0;
    redirect_go     = 1'b0;
    f_stall_raw     = 1'b0;
    t_stall_raw     = 1'b0;
    d_stall_raw     = 1'b0;
    e_stall_raw     = 1'b0;
    m_stall_raw     = 1'b0;
    t_bubble_raw    = 1'b0;
    d_bubble_raw    = 1'b0;
    e_bubble_raw    = 1'b0;
    w_bubble_raw    = 1'b0;

    case (state)
      RUN: begin
        if (m_mem_req && !m_mem_ready) begin
          mem_hold        = 1'b1;
          state_n         = MEM_WAIT;
          redirect_pend_n = redirect_pend || e_redirect;
        end else if (e_redirect) begin
          redirect_go = 1'b1;
        end else if (load_use) begin
          f_stall_raw  = 1'b1;
          t_stall_raw  = 1'b1;
          d_stall_raw  = 1'b1;
          e_bubble_raw = 1'b1;
        end
      end

      MEM_WAIT: begin
        if (!m_mem_ready) begin
          mem_hold        = 1'b1;
          redirect_pend_n = redirect_pend || e_redirect;
        end else if (redirect_pend || e_redirect) begin
          redirect_go = 1'b1;
        end else if (flush_cnt != 2'd0) begin
          state_n = FLUSH;
        end else begin
          state_n = RUN;
        end
      end

      FLUSH: begin
        if (m_mem_req && !m_mem_ready) begin
          mem_hold        = 1'b1;
          state_n         = MEM_WAIT;
          redirect_pend_n = redirect_pend || e_redirect;
        end else if (e_redirect) begin
          redirect_go = 1'b1;
        end else begin
          t_bubble_raw = 1'b1;
          if (flush_cnt <= 2'd1) begin
            flush_cnt_n = 2'd0;
            state_n     = RUN;
          end else begin
            flush_cnt_n = flush_cnt - 2'd1;
          end
        end
      end

      default: begin
        state_n = RUN;
      end
    endcase

    if (mem_hold) begin
      f_stall_raw  = 1'b1;
      t_stall_raw  = 1'b1;
      d_stall_raw  = 1'b1;
      e_stall_raw  = 1'b1;
      m_stall_raw  = 1'b1;
      w_bubble_raw = 1'b1;
    end

    if (redirect_go) begin
      t_bubble_raw    = 1'b1;
      d_bubble_raw    = 1'b1;
      e_bubble_raw    = 1'b1;
      flush_cnt_n     = FLUSH_INIT;
      redirect_pend_n = 1'b0;
      state_n         = (FLUSH_LAT > 1) ? FLUSH : RUN;
    end
  end

  // Outputs are quiet during reset; a bubble overrides a hold on the same register.
  always_comb begin
    f_stall  = !reset && f_stall_raw;
    t_stall  = !reset && t_stall_raw && !t_bubble_raw;
    d_stall  = !reset && d_stall_raw && !d_bubble_raw;
    e_stall  = !reset && e_stall_raw && !e_bubble_raw;
    m_stall  = !reset && m_stall_raw;
    t_bubble = !reset && t_bubble_raw;
    d_bubble = !reset && d_bubble_raw;
    e_bubble = !reset && e_bubble_raw;
    w_bubble = !reset && w_bubble_raw;
  end

`ifdef PIPE_CTRL_PERF_EN
  localparam logic [PERF_W-1:0] PERF_ONE = {{(PERF_W-1){1'b0}}, 1'b1};

  logic [PERF_W-1:0] stall_cnt_q;
  logic [PERF_W-1:0] flush_cnt_q;

  // Free-running, wrapping event counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (f_stall) begin
        stall_cnt_q <= stall_cnt_q + PERF_ONE;
      end
      if (redirect_go) begin
        flush_cnt_q <= flush_cnt_q + PERF_ONE;
      end
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl with a cycle-level reference model.
module tb_pipeline_ctrl;

  localparam int FLUSH_LAT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  d_ra, d_rb, e_rn;
  logic        d_need_ra, d_need_rb, e_wreg, e_m2reg;
  logic        e_redirect, m_mem_req, m_mem_ready;
  logic        t_stall, d_stall, e_stall, m_stall, f_stall;
  logic        t_bubble, d_bubble, e_bubble, w_bubble;
  logic [31:0] perf_stall_cnt, perf_flush_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: outstanding memory wait, deferred redirect,
  // remaining T bubbles of a flush, event counters.
  bit          m_waiting;
  bit          m_pend;
  int          m_flush_left;
  logic [31:0] m_perf_stall;
  logic [31:0] m_perf_flush;

  pipeline_ctrl #(.FLUSH_LAT(FLUSH_LAT)) dut (
    .clk            (clk),
    .reset          (reset),
    .d_ra           (d_ra),
    .d_rb           (d_rb),
    .d_need_ra      (d_need_ra),
    .d_need_rb      (d_need_rb),
    .e_rn           (e_rn),
    .e_wreg         (e_wreg),
    .e_m2reg        (e_m2reg),
    .e_redirect     (e_redirect),
    .m_mem_req      (m_mem_req),
    .m_mem_ready    (m_mem_ready),
    .t_stall        (t_stall),
    .d_stall        (d_stall),
    .e_stall        (e_stall),
    .m_stall        (m_stall),
    .f_stall        (f_stall),
    .t_bubble       (t_bubble),
    .d_bubble       (d_bubble),
    .e_bubble       (e_bubble),
    .w_bubble       (w_bubble),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_idle();
    reset       = 1'b0;
    d_ra        = 5'd0;
    d_rb        = 5'd0;
    d_need_ra   = 1'b0;
    d_need_rb   = 1'b0;
    e_rn        = 5'd0;
    e_wreg      = 1'b0;
    e_m2reg     = 1'b0;
    e_redirect  = 1'b0;
    m_mem_req   = 1'b0;
    m_mem_ready = 1'b0;
  endtask

  // One clock: predict from current inputs, compare mid-cycle, advance model.
  // Vector order {f,t,d,e,m stall, t,d,e,w bubble}.
  task automatic step(input string tag);
    logic [8:0]  exp_o;
    logic [8:0]  obs_o;
    logic [31:0] exp_ps, exp_pf;
    bit          mw, lu, redir_now;
    @(negedge clk);
    exp_o = 9'b0;
    lu = e_wreg && e_m2reg && (e_rn != 5'd0) &&
         ((d_need_ra && d_ra == e_rn) || (d_need_rb && d_rb == e_rn));
    `ifdef PIPE_CTRL_PERF_EN
    exp_ps = m_perf_stall;
    exp_pf = m_perf_flush;
    `else
    exp_ps = 32'd0;
    exp_pf = 32'd0;
    `endif
    obs_o = {f_stall, t_stall, d_stall, e_stall, m_stall,
             t_bubble, d_bubble, e_bubble, w_bubble};

    if (!reset) begin
      mw        = m_waiting ? !m_mem_ready : (m_mem_req && !m_mem_ready);
      redir_now = m_waiting ? (m_pend || e_redirect) : e_redirect;
      if (mw) begin
        exp_o = 9'b11111_0001;
      end else if (redir_now) begin
        exp_o = 9'b00000_1110;
      end else if (!m_waiting && m_flush_left > 0) begin
        exp_o = 9'b00000_1000;
      end else if (!m_waiting && lu) begin
        exp_o = 9'b11100_0010;
      end
    end

    chk({tag, ":out"}, {23'd0, obs_o}, {23'd0, exp_o});
    chk({tag, ":perf_stall"}, perf_stall_cnt, exp_ps);
    chk({tag, ":perf_flush"}, perf_flush_cnt, exp_pf);

    if (reset) begin
      m_waiting    = 0;
      m_pend       = 0;
      m_flush_left = 0;
      m_perf_stall = 32'd0;
      m_perf_flush = 32'd0;
    end else begin
      if (exp_o[8]) m_perf_stall = m_perf_stall + 32'd1;
      if (mw) begin
        m_waiting = 1;
        m_pend    = m_pend || e_redirect;
      end else if (redir_now) begin
        m_waiting    = 0;
        m_pend       = 0;
        m_flush_left = FLUSH_LAT - 1;
        m_perf_flush = m_perf_flush + 32'd1;
      end else if (m_waiting) begin
        m_waiting = 0;
      end else if (m_flush_left > 0) begin
        m_flush_left--;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    m_waiting    = 0;
    m_pend       = 0;
    m_flush_left = 0;
    m_perf_stall = 32'd0;
    m_perf_flush = 32'd0;
    set_idle();
    reset = 1'b1;
    @(posedge clk);
    #1;
    step("reset");
    reset = 1'b0;
    step("idle");

    // Load-use on ra, then r0 as destination must not interlock.
    e_rn = 5'd5; e_wreg = 1'b1; e_m2reg = 1'b1; d_ra = 5'd5; d_need_ra = 1'b1;
    step("lu_ra");
    set_idle();
    step("lu_clear");
    e_wreg = 1'b1; e_m2reg = 1'b1; d_need_ra = 1'b1; d_need_rb = 1'b1;
    step("lu_r0");
    e_rn = 5'd9; d_rb = 5'd9;
    step("lu_rb");
    set_idle();
    step("idle");

    // Memory wait: three held cycles, released on the fourth.
    m_mem_req = 1'b1;
    repeat (3) step("memwait");
    m_mem_ready = 1'b1;
    step("memready");
    set_idle();
    step("idle");

    // One-cycle redirect, full flush sequence.
    e_redirect = 1'b1;
    step("redir");
    e_redirect = 1'b0;
    repeat (4) step("flush");

    // Redirect during a memory wait is deferred to the ready cycle.
    m_mem_req = 1'b1;
    step("mw_redir_0");
    e_redirect = 1'b1;
    step("mw_redir_1");
    e_redirect = 1'b0;
    repeat (2) step("mw_redir_w");
    m_mem_ready = 1'b1;
    step("mw_redir_rdy");
    set_idle();
    repeat (3) step("mw_redir_fl");

    // Load-use together with redirect: redirect only.
    e_rn = 5'd7; e_wreg = 1'b1; e_m2reg = 1'b1; d_ra = 5'd7; d_need_ra = 1'b1;
    e_redirect = 1'b1;
    step("lu_redir");
    set_idle();
    repeat (3) step("lu_redir_fl");

    // Reset in the first flush cycle abandons the flush.
    e_redirect = 1'b1;
    step("rst_flush_0");
    e_redirect = 1'b0;
    reset = 1'b1;
    step("rst_flush_1");
    reset = 1'b0;
    repeat (2) step("rst_after");

    // Randomized traffic with small register set to provoke hazards.
    for (int i = 0; i < 3000; i++) begin
      reset       = ($urandom % 150) == 0;
      d_ra        = 5'($urandom % 4);
      d_rb        = 5'($urandom % 4);
      e_rn        = 5'($urandom % 4);
      d_need_ra   = 1'($urandom % 2);
      d_need_rb   = 1'($urandom % 2);
      e_wreg      = ($urandom % 4) != 0;
      e_m2reg     = ($urandom % 2) == 0;
      e_redirect  = ($urandom % 10) == 0;
      m_mem_req   = ($urandom % 4) == 0;
      m_mem_ready = ($urandom % 3) == 0;
      step("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
